// File: rtl/display_pkg.sv
// Shared definitions for the BCD conversion and seven-segment display blocks.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FIN
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    // Double-dabble correction: a digit of 5 or more overflows past 9 once doubled.
    function automatic logic [3:0] bcd_adj3(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/bcd_adj_shift.sv
// One shift-add-3 step: adjust every BCD digit of the shift register, then shift left by one.
module bcd_adj_shift
    import display_pkg::*;
#(
    parameter int w_bin = 14,
    parameter int n_dig = 4
) (
    input  logic [n_dig*4+w_bin-1:0] sh,
    output logic [n_dig*4+w_bin-1:0] sh_shifted,
    output logic                     carry
);

    localparam int SH_W = n_dig * 4 + w_bin;

    logic [SH_W-1:0] adj;

    assign adj[w_bin-1:0] = sh[w_bin-1:0];

    generate
        for (genvar gi = 0; gi < n_dig; gi++) begin : g_digit
            assign adj[w_bin + gi*4 +: 4] = bcd_adj3(sh[w_bin + gi*4 +: 4]);
        end
    endgenerate

    // The bit leaving the top digit carries weight 10^n_dig.
    assign {carry, sh_shifted} = {adj, 1'b0};

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, with saturation on overflow.
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int w_bin = 14,
    parameter int n_dig = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [w_bin-1:0]   bin,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [n_dig*4-1:0] bcd,
    output logic               ovf,
    output logic               done
);

    localparam int BCD_W = n_dig * 4;
    localparam int SH_W  = BCD_W + w_bin;
    localparam int CNT_W = $clog2(w_bin + 1);

    state_t           state_reg, state_next;
    logic [SH_W-1:0]  sh_reg, sh_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             of_reg, of_next;
    logic [BCD_W-1:0] bcd_reg, bcd_next;
    logic             ovf_reg, ovf_next;
    logic             done_reg, done_next;

    logic [SH_W-1:0]  sh_step;
    logic             carry_step;

    bcd_adj_shift #(
        .w_bin(w_bin),
        .n_dig(n_dig)
    ) u_adj_shift (
        .sh        (sh_reg),
        .sh_shifted(sh_step),
        .carry     (carry_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            sh_reg    <= '0;
            cnt_reg   <= '0;
            of_reg    <= 1'b0;
            bcd_reg   <= '0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sh_reg    <= sh_next;
            cnt_reg   <= cnt_next;
            of_reg    <= of_next;
            bcd_reg   <= bcd_next;
            ovf_reg   <= ovf_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sh_next    = sh_reg;
        cnt_next   = cnt_reg;
        of_next    = of_reg;
        bcd_next   = bcd_reg;
        ovf_next   = ovf_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sh_next    = {{BCD_W{1'b0}}, bin};
                    of_next    = 1'b0;
                    cnt_next   = CNT_W'(w_bin);
                    state_next = CONV;
                end
            end
            CONV: begin
                sh_next  = sh_step;
                of_next  = of_reg | carry_step;
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                bcd_next   = of_reg ? {n_dig{BCD_NINE}} : sh_reg[SH_W-1 -: BCD_W];
                ovf_next   = of_reg;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready = (state_reg == IDLE);
    assign bcd      = bcd_reg;
    assign ovf      = ovf_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: directed vectors, monitor pops expected results on done.
module tb_bin_to_bcd_seq;

    localparam int LAT_NEG = 16;  // negedge index distance from acceptance sample to done sample
    localparam int RDY_LOW = 15;  // cycles in_ready stays low per conversion

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] bin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd;
    logic        ovf;
    logic        done;

    logic [12:0] bin13;
    logic        valid13, ready13, ovf13, done13;
    logic [15:0] bcd13;
    logic [3:0]  bin4;
    logic        valid4, ready4, ovf4, done4;
    logic [7:0]  bcd4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_gap = 0;
    int prev_done_cyc = -1;
    int rdy_run  = 0;
    logic [15:0] last_bcd = '0;
    logic        last_ovf = 1'b0;

    logic [16:0] exp_q[$];
    int          acc_q[$];

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.w_bin(14), .n_dig(4)) u_dut (
        .clk(clk), .reset(reset), .bin(bin), .in_valid(in_valid),
        .in_ready(in_ready), .bcd(bcd), .ovf(ovf), .done(done)
    );

    bin_to_bcd_seq #(.w_bin(13), .n_dig(4)) u_dut13 (
        .clk(clk), .reset(reset), .bin(bin13), .in_valid(valid13),
        .in_ready(ready13), .bcd(bcd13), .ovf(ovf13), .done(done13)
    );

    bin_to_bcd_seq #(.w_bin(4), .n_dig(2)) u_dut4 (
        .clk(clk), .reset(reset), .bin(bin4), .in_valid(valid4),
        .in_ready(ready4), .bcd(bcd4), .ovf(ovf4), .done(done4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: latency, in_ready low time, result scoreboard and output hold.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            acc_q.delete();
            rdy_run  = 0;
            last_bcd = '0;
            last_ovf = 1'b0;
            check("reset_done", {31'd0, done}, 32'd0);
        end else begin
            if (in_valid && in_ready) acc_q.push_back(cyc);
            if (!in_ready) begin
                rdy_run++;
            end else if (rdy_run != 0) begin
                check("ready_low_cycles", rdy_run, RDY_LOW);
                rdy_run = 0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("bcd", {16'd0, bcd}, {16'd0, e[16:1]});
                    check("ovf", {31'd0, ovf}, {31'd0, e[0]});
                    $display("txn: bcd=%04h ovf=%0b expected bcd=%04h ovf=%0b", bcd, ovf, e[16:1], e[0]);
                end
                if (acc_q.size() != 0) check("latency", cyc - acc_q.pop_front(), LAT_NEG);
                else check("latency_no_accept", 32'd1, 32'd0);
                if (prev_done_cyc >= 0) done_gap = cyc - prev_done_cyc;
                prev_done_cyc = cyc;
                last_bcd = bcd;
                last_ovf = ovf;
            end else begin
                check("bcd_hold", {15'd0, bcd, ovf}, {15'd0, last_bcd, last_ovf});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("wait_ready_timeout", 32'd1, 32'd0);
    endtask

    task automatic accept(input logic [13:0] v, input logic [15:0] eb, input logic eo);
        wait_ready();
        bin      = v;
        in_valid = 1'b1;
        exp_q.push_back({eb, eo});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) check("scoreboard_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        reset = 1'b0; in_valid = 1'b0; bin = '0;
        valid13 = 1'b0; bin13 = '0; valid4 = 1'b0; bin4 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);
        check("bcd_after_reset", {16'd0, bcd}, 32'd0);
        check("ovf_after_reset", {31'd0, ovf}, 32'd0);

        accept(14'd1234, 16'h1234, 1'b0);
        wait_empty();

        // Back-to-back with in_valid held high.
        bin = 14'd0; in_valid = 1'b1;
        exp_q.push_back({16'h0000, 1'b0});
        @(posedge clk); #1;
        bin = 14'd9999;
        exp_q.push_back({16'h9999, 1'b0});
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_empty();
        check("b2b_done_gap", done_gap, 16);

        accept(14'd10000, 16'h9999, 1'b1);
        wait_empty();
        accept(14'd16383, 16'h9999, 1'b1);
        wait_empty();
        accept(14'd42, 16'h0042, 1'b0);
        wait_empty();

        // Input activity during conversion must be ignored.
        accept(14'd5678, 16'h5678, 1'b0);
        for (int i = 0; i < 6; i++) begin
            bin = 14'd1111;
            in_valid = ~in_valid;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_empty();
        repeat (20) @(posedge clk);
        #1 check("idle_after_ignored", {31'd0, in_ready}, 32'd1);

        // Abort in the middle of a conversion.
        wait_ready();
        bin = 14'd4321; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("abort_bcd", {16'd0, bcd}, 32'd0);
        check("abort_ovf", {31'd0, ovf}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("ready_after_abort", {31'd0, in_ready}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        accept(14'd8, 16'h0008, 1'b0);
        wait_empty();

        // Other parameterisations.
        bin13 = 13'd8191; valid13 = 1'b1;
        bin4  = 4'd15;    valid4  = 1'b1;
        @(posedge clk); #1;
        valid13 = 1'b0; valid4 = 1'b0;
        n = 0;
        while (!(done13 && done4) && n < 8) begin
            @(negedge clk);
            if (done4) begin
                check("w4_bcd", {24'd0, bcd4}, 32'h15);
                check("w4_ovf", {31'd0, ovf4}, 32'd0);
                $display("txn w4: bcd=%02h ovf=%0b", bcd4, ovf4);
            end
            n++;
        end
        n = 0;
        while (!done13 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (done13) begin
            check("w13_bcd", {16'd0, bcd13}, 32'h8191);
            check("w13_ovf", {31'd0, ovf13}, 32'd0);
            $display("txn w13: bcd=%04h ovf=%0b", bcd13, ovf13);
        end else begin
            check("w13_timeout", 32'd1, 32'd0);
        end
        check("w4_result_held", {23'd0, bcd4, ovf4}, {23'd0, 8'h15, 1'b0});
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-add-3, one bit per clock) that feeds the packed `number` input of the dynamic seven-segment display driver.
- Accepts a binary word through a valid/ready handshake and holds the n_dig-digit BCD result stable between conversions.
- Flags and saturates values that do not fit in n_dig decimal digits.

Parameters:
- w_bin, 14, width of the binary input in bits (>= 4).
- n_dig, 4, number of BCD digits produced; result width is n_dig*4.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- bin  input  w_bin  binary value to convert; sampled only on acceptance.
- in_valid  input  1  request to convert bin.
- in_ready  output  1  high only in IDLE; acceptance = in_valid & in_ready at a rising clk edge.
- bcd  output  n_dig*4  registered result, digit k in bits [k*4 +: 4], digit 0 least significant; connects directly to the display driver `number`.
- ovf  output  1  registered; high if the last accepted value exceeded 10^n_dig - 1.
- done  output  1  one-cycle pulse; bcd/ovf updated in this same cycle.

Behaviour:
- Reset (reset low, asynchronous) forces: state=IDLE, bcd=0, ovf=0, done=0. As a result in_ready=1 immediately after reset deasserts. A reset during a conversion aborts it; no done pulse follows.
- States: IDLE, CONV, FIN.
- IDLE:
  - On acceptance, load shift register sh = {n_dig*4 zero bits, bin}, clear sticky overflow flag of, set bit counter cnt = w_bin, go to CONV.
  - in_valid without acceptance has no effect.
- CONV, once per cycle:
  - For each of the n_dig BCD nibbles of sh, add 3 if the nibble >= 5 (4-bit add, no inter-digit carry).
  - Shift the whole adjusted register left by 1.
  - The bit shifted out of the top digit ORs into of.
  - Decrement cnt; when cnt reaches 0 after the shift, go to FIN. This takes exactly w_bin cycles.
- FIN:
  - bcd <= of ? all digits 4'h9 : upper n_dig*4 bits of sh.
  - ovf <= of; done <= 1 for this one cycle; go to IDLE.
- Latency: acceptance at edge E0, so done=1 and the new bcd are visible in the cycle after edge E(w_bin+1).
- in_ready is low in CONV and FIN. It is high again in the cycle done is high, so back-to-back conversions have a w_bin+2 cycle period.
- in_valid during CONV/FIN is ignored; bin changes after acceptance do not affect the result.
- bcd and ovf hold their values from FIN until the next FIN; there is never a partial value on bcd.
- Overflow detection must be exact:
  - Value 10^n_dig - 1 gives ovf=0.
  - Value 10^n_dig gives ovf=1.
  - Any value >= 2^(n_dig*4) that fits in w_bin also gives ovf=1.
- cnt width is $clog2(w_bin+1); no wrap is possible.
- bin=0 produces bcd=0, ovf=0 after the full w_bin cycles; there is no early exit.

Decomposition:
- Shared package display_pkg:
  - state enum {IDLE, CONV, FIN}.
  - Constant BCD_NINE = 4'h9.
  - Function bcd_adj3(nibble), returning nibble + 3 when >= 5, else nibble. The function is shared with future BCD counters.
- One natural sub-module: bcd_adj_shift, combinational, parameterised by w_bin and n_dig. It takes sh and returns {shifted-out bit, adjusted-and-shifted sh}. It is instantiated once in bin_to_bcd_seq; the FSM, counter and output registers stay in the top.

Test Plan:
- Reset, then accept bin=1234 (w_bin=14, n_dig=4) -> done pulses 15 cycles after the acceptance edge, bcd=16'h1234, ovf=0, in_ready low for exactly 15 cycles.
- Accept 0, then 9999 back-to-back, in_valid held high -> bcd=16'h0000 then 16'h9999, two done pulses 16 cycles apart, ovf=0 both.
- Accept 10000, then 16383 -> bcd=16'h9999 with ovf=1 for each; next accept 42 -> bcd=16'h0042, ovf=0.
- Accept 5678, toggle in_valid and change bin to 1111 during CONV -> single done, bcd=16'h5678, no second conversion started.
- Accept 4321 and assert reset at cycle 7 of CONV -> bcd=0, ovf=0, done never pulses; after release, in_ready=1 and accept 8 -> bcd=16'h0008.
- Parameter sweep w_bin=13, n_dig=4 with 8191 and w_bin=4, n_dig=2 with 15 -> bcd 16'h8191 and 8'h15, ovf=0.
